bus_copy_master: RTL

- Initiator on the PicoRV32 native memory bus (valid/ready/addr/wdata/wstrb/rdata): the master side that program memory and peripheral responders answer to.
- On a start pulse it copies len_words 32-bit words from src_addr to dst_addr, one read then one write per word.
- Used in the SPI demo SoC to move code/data between memories, e.g. staging an image into progmem-style RAM, without CPU involvement.
- Reports completion, word count and a timeout/abort error.

---
 rtl/bus_copy_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bus_copy_master.sv
// bus_copy_master
//   Copies a block of 32-bit words from one address to another. It acts as
//   the initiator on a PicoRV32-style native memory bus. Each word is moved
//   with one read followed by one write. A single idle cycle separates
//   consecutive bus transactions.
//
// Ports
//   clk, rstn          clock; asynchronous active-low reset
//   start              request, sampled only while idle
//   src_addr/dst_addr  byte addresses; the low two bits are ignored
//   len_words          number of words to copy (0 completes immediately)
//   abort              stops the copy at the next transaction boundary
//   busy/done/err      status; done is a one-cycle pulse, err is sticky
//   count              words fully written in the current or last transfer
//   mem_*              native memory bus, master side
module bus_copy_master #(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] count,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_GAP,
    WR,
    WR_GAP,
    FIN
  } state_e;

  // A timeout of zero means the bus may stall forever.
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      buf_q, buf_d;
  logic [31:0]      tmo_q, tmo_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             tmo_hit;

  // tmo_q counts the cycles the current request has waited. The request
  // expires on the edge that ends its TIMEOUT_CYCLES-th cycle.
  assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    tmo_d   = tmo_q;
    len_d   = len_q;
    count_d = count_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr & 32'hFFFF_FFFC;
          dst_d   = dst_addr & 32'hFFFF_FFFC;
          len_d   = len_words;
          count_d = '0;
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = (len_words == '0) ? FIN : RD;
        end
      end

      RD: begin
        // A ready on the expiry edge still completes the read.
        if (mem_ready) begin
          buf_d   = mem_rdata;
          src_d   = src_q + 32'd4;
          state_d = RD_GAP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (TMO_EN) begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      RD_GAP: begin
        tmo_d = '0;
        if (abort) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = WR;
        end
      end

      WR: begin
        if (mem_ready) begin
          dst_d   = dst_q + 32'd4;
          count_d = count_q + LEN_W'(1);
          state_d = (count_d == len_q) ? FIN : WR_GAP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (TMO_EN) begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      WR_GAP: begin
        tmo_d = '0;
        if (abort) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = RD;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      tmo_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      tmo_q   <= tmo_d;
      len_q   <= len_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // The bus outputs decode straight from registered state. They cannot
  // change while a request is held, and they drop on the completing edge.
  assign mem_valid = (state_q == RD) || (state_q == WR);
  assign mem_addr  = (state_q == RD) ? src_q : ((state_q == WR) ? dst_q : 32'd0);
  assign mem_wdata = (state_q == WR) ? buf_q : 32'd0;
  assign mem_wstrb = (state_q == WR) ? 4'hF : 4'h0;

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == FIN);
  assign err   = err_q;
  assign count = count_q;

endmodule
